// File: rtl/key_pkg.sv
// Shared types and constants for the key scan debounce controller.
package key_pkg;

  // Debounce scheduler states
  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StConfirm
  } key_state_e;

  // 20 ms and 1 s at 50 MHz
  localparam int unsigned DefDelay     = 1000000;
  localparam int unsigned DefLongDelay = 50000000;

  // Width of a key index; never narrower than one bit
  function automatic int unsigned key_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_rr_pick.sv
// Combinational round-robin selector: grants the first requesting key
// strictly after the pointer, wrapping around.
module key_rr_pick
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS = 4,
  parameter int unsigned IDX_W    = key_idx_w(NUM_KEYS)
) (
  input  logic [NUM_KEYS-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                any_req
);

  logic             found;
  int               j;
  logic [IDX_W-1:0] jj;

  // Scan the request vector starting one past the pointer
  always_comb begin
    any_req   = |req;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    jj        = '0;
    for (int i = 1; i <= int'(NUM_KEYS); i++) begin
      j = int'(ptr) + i;
      if (j >= int'(NUM_KEYS)) begin
        j = j - int'(NUM_KEYS);
      end
      jj = IDX_W'(j);
      if (!found && req[jj]) begin
        grant_idx = jj;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_scan_ctrl.sv
// Shared-counter debounce controller for a bank of active-low push-buttons.
// One debounce counter is time-shared among all keys via a round-robin grant.
// Optional long-press detection is enabled by defining KEY_LONG_PRESS_EN.
module key_scan_ctrl
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS   = 4,
  parameter int unsigned DELAY      = DefDelay,
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned LONG_DELAY = DefLongDelay
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_KEYS-1:0]          key,
  output logic [NUM_KEYS-1:0]          key_level,
  output logic [NUM_KEYS-1:0]          press_pulse,
  output logic [NUM_KEYS-1:0]          release_pulse,
  output logic                         key_valid,
  output logic [key_idx_w(NUM_KEYS)-1:0] key_code,
  output logic                         busy,
  output logic [NUM_KEYS-1:0]          long_pulse
);

  localparam int unsigned IDX_W = key_idx_w(NUM_KEYS);

  key_state_e state_q, state_d;

  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  logic [NUM_KEYS-1:0] level_q, level_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic                valid_q, valid_d;
  logic [IDX_W-1:0]    code_q, code_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                cand_q, cand_d;

  logic [NUM_KEYS-1:0] change;
  logic [IDX_W-1:0]    pick_idx;
  logic                any_req;

  // Two-flop synchronizer on the raw pins; idle (released) level is 1
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
    end
  end

  // A key requests the counter while its synchronized and debounced levels differ
  assign change = sync2_q ^ level_q;

  key_rr_pick #(
    .NUM_KEYS (NUM_KEYS),
    .IDX_W    (IDX_W)
  ) u_rr_pick (
    .req       (change),
    .ptr       (ptr_q),
    .grant_idx (pick_idx),
    .any_req   (any_req)
  );

  // Scheduler state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      level_q   <= '1;
      press_q   <= '0;
      release_q <= '0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      cnt_q     <= '0;
      ptr_q     <= IDX_W'(NUM_KEYS - 1);
      idx_q     <= '0;
      cand_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cand_q    <= cand_d;
    end
  end

  // Grant, count the stability window, then commit the new level and pulse
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    valid_d   = 1'b0;
    code_d    = code_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cand_d    = cand_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          idx_d   = pick_idx;
          cand_d  = sync2_q[pick_idx];
          cnt_d   = CNT_W'(DELAY - 1);
          state_d = StCount;
        end
      end
      StCount: begin
        // Granted key bounced back: drop it, rotate past it, restart later
        if (sync2_q[idx_q] == level_q[idx_q]) begin
          ptr_d   = idx_q;
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StConfirm;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StConfirm: begin
        level_d[idx_q] = cand_q;
        ptr_d          = idx_q;
        if (!cand_q) begin
          press_d[idx_q] = 1'b1;
        end else begin
          release_d[idx_q] = 1'b1;
        end
        valid_d = 1'b1;
        code_d  = idx_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign key_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign key_valid     = valid_q;
  assign key_code      = code_q;
  assign busy          = (state_q != StIdle);

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned LONG_W = $clog2(LONG_DELAY);

  logic [LONG_W-1:0]   long_cnt_q, long_cnt_d;
  logic [IDX_W-1:0]    long_key_q, long_key_d;
  logic                long_armed_q, long_armed_d;
  logic [NUM_KEYS-1:0] long_q, long_d;
  logic                press_evt;

  assign press_evt = (state_q == StConfirm) && !cand_q;

  // Long-press tracker registers
  always_ff @(posedge clk) begin
    if (rst) begin
      long_cnt_q   <= '0;
      long_key_q   <= '0;
      long_armed_q <= 1'b0;
      long_q       <= '0;
    end else begin
      long_cnt_q   <= long_cnt_d;
      long_key_q   <= long_key_d;
      long_armed_q <= long_armed_d;
      long_q       <= long_d;
    end
  end

  // Follow only the newest press; a release of that key disarms it
  always_comb begin
    long_cnt_d   = long_cnt_q;
    long_key_d   = long_key_q;
    long_armed_d = long_armed_q;
    long_d       = '0;
    if (press_evt) begin
      long_armed_d = 1'b1;
      long_key_d   = idx_q;
      long_cnt_d   = LONG_W'(LONG_DELAY - 1);
    end else if (long_armed_q) begin
      if (level_q[long_key_q]) begin
        long_armed_d = 1'b0;
      end else if (long_cnt_q == '0) begin
        long_d[long_key_q] = 1'b1;
        long_armed_d       = 1'b0;
      end else begin
        long_cnt_d = long_cnt_q - 1'b1;
      end
    end
  end

  assign long_pulse = long_q;
`else
  assign long_pulse = '0;
`endif

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Self-checking bench for key_scan_ctrl with DELAY=8, NUM_KEYS=4, LONG_DELAY=32.
module tb_key_scan_ctrl;

  localparam int NK   = 4;
  localparam int DLY  = 8;
  localparam int CW   = 4;
  localparam int LDLY = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key;
  logic [NK-1:0] key_level, press_pulse, release_pulse, long_pulse;
  logic          key_valid, busy;
  logic [1:0]    key_code;

  always #5 clk = ~clk;

  key_scan_ctrl #(
    .NUM_KEYS   (NK),
    .DELAY      (DLY),
    .CNT_W      (CW),
    .LONG_DELAY (LDLY)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key           (key),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .busy          (busy),
    .long_pulse    (long_pulse)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-key levels, a single service slot measured by elapsed
  // cycles since grant, and a round-robin pointer.
  logic [NK-1:0] m_s1 = '1, m_s2 = '1, m_level = '1;
  logic [NK-1:0] m_press = '0, m_rel = '0, m_long = '0;
  logic          m_valid = 1'b0;
  int            m_code = 0, m_ptr = NK - 1, m_srv = -1, m_age = 0;
  logic          m_cand = 1'b1;
  logic          m_armed = 1'b0;
  int            m_lkey = 0, m_lage = 0;

  initial begin : compare_proc
    logic [NK-1:0] chg, old_level;
    logic          press_now, found;
    int            j, ones;
    forever begin
      @(negedge clk);
      chk("key_level", 32'(key_level), 32'(m_level));
      chk("press_pulse", 32'(press_pulse), 32'(m_press));
      chk("release_pulse", 32'(release_pulse), 32'(m_rel));
      chk("key_valid", 32'(key_valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_srv >= 0));
      chk("long_pulse", 32'(long_pulse), 32'(m_long));
      if (m_valid) chk("key_code", 32'(key_code), 32'(m_code));
      ones = $countones(press_pulse | release_pulse);
      chk("one_event", 32'(ones <= 1), 32'd1);
      // Advance the model with the inputs the next edge will sample
      if (rst) begin
        m_s1 = '1; m_s2 = '1; m_level = '1;
        m_press = '0; m_rel = '0; m_long = '0; m_valid = 1'b0; m_code = 0;
        m_ptr = NK - 1; m_srv = -1; m_age = 0; m_cand = 1'b1;
        m_armed = 1'b0; m_lkey = 0; m_lage = 0;
      end else begin
        old_level = m_level;
        m_press = '0; m_rel = '0; m_long = '0; m_valid = 1'b0;
        press_now = (m_srv >= 0) && (m_age == DLY + 1) && !m_cand;
`ifdef KEY_LONG_PRESS_EN
        if (press_now) begin
          m_armed = 1'b1; m_lkey = m_srv; m_lage = 0;
        end else if (m_armed) begin
          if (old_level[m_lkey]) begin
            m_armed = 1'b0;
          end else begin
            m_lage++;
            if (m_lage == LDLY) begin
              m_long[m_lkey] = 1'b1;
              m_armed = 1'b0;
            end
          end
        end
`endif
        if (m_srv < 0) begin
          chg = m_s2 ^ m_level;
          found = 1'b0;
          for (int i = 1; i <= NK; i++) begin
            j = (m_ptr + i) % NK;
            if (!found && chg[j]) begin
              found = 1'b1; m_srv = j; m_cand = m_s2[j]; m_age = 1;
            end
          end
        end else if (m_age <= DLY) begin
          if (m_s2[m_srv] == m_level[m_srv]) begin
            m_ptr = m_srv; m_srv = -1;
          end else begin
            m_age++;
          end
        end else begin
          m_level[m_srv] = m_cand;
          if (m_cand) m_rel[m_srv] = 1'b1;
          else m_press[m_srv] = 1'b1;
          m_valid = 1'b1; m_code = m_srv; m_ptr = m_srv; m_srv = -1;
        end
        m_s2 = m_s1;
        m_s1 = key;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Count edges from the current pin change until the wanted pulse is seen
  task automatic wait_evt(input int k, input bit is_press, input string name, input int exp_n);
    bit hit;
    int n;
    hit = 1'b0;
    n = 0;
    while (!hit && n < 300) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      hit = is_press ? press_pulse[k] : release_pulse[k];
    end
    chk(name, 32'(n), 32'(exp_n));
    if (hit) begin
      chk({name, "_code"}, 32'(key_code), 32'(k));
      chk({name, "_valid"}, 32'(key_valid), 32'd1);
      chk({name, "_level"}, 32'(key_level[k]), 32'(!is_press));
    end
  endtask

  initial begin : stim
    int n;
    bit hit;
    rst = 1'b1;
    key = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_level", 32'(key_level), 32'hF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_press", 32'(press_pulse), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(3);

    // Clean press on key 0
    key[0] = 1'b0;
    wait_evt(0, 1'b1, "press0_lat", 12);
    @(negedge clk);
    chk("press0_width", 32'(press_pulse), 32'd0);
    tick(5);

    // Bounce on key 1: low 3, high 2, then low and held
    key[1] = 1'b0;
    tick(3);
    key[1] = 1'b1;
    tick(2);
    key[1] = 1'b0;
    wait_evt(1, 1'b1, "bounce1_lat", 12);
    tick(5);

    // Keys 2 and 3 together: served 2 then 3, one full slot apart
    key[3:2] = 2'b00;
    wait_evt(2, 1'b1, "cont2_lat", 12);
    wait_evt(3, 1'b1, "cont3_gap", 10);
    tick(5);

    // Release key 0
    key[0] = 1'b1;
    wait_evt(0, 1'b0, "release0_lat", 12);
    chk("release0_nopress", 32'(press_pulse), 32'd0);
    tick(5);

    // Reset while the counter is running for a release of key 1
    key[1] = 1'b1;
    hit = 1'b0;
    n = 0;
    while (!hit && n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      hit = busy;
    end
    chk("busy_seen", 32'(hit), 32'd1);
    tick(3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_level", 32'(key_level), 32'hF);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(key_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(60);

`ifdef KEY_LONG_PRESS_EN
    key = '1;
    tick(80);
    key[0] = 1'b0;
    wait_evt(0, 1'b1, "lp_press", 12);
    hit = 1'b0;
    n = 0;
    while (!hit && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      hit = long_pulse[0];
    end
    chk("lp_delay", 32'(n), 32'(LDLY));
    tick(10);
    key[0] = 1'b1;
    tick(30);
    key[1] = 1'b0;
    tick(10);
    key[1] = 1'b1;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (long_pulse != '0) n++;
    end
    chk("lp_early_release", 32'(n), 32'd0);
`endif

    tick(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
